stopwatch_core: RTL and testbench

Stopwatch time-keeping stage that sits directly downstream of the clock divider. It consumes the divider's 1 Hz tick, 2 Hz tick, debounce-sample tick and blink square wave, and debounces the raw push-buttons. It runs a run/pause/clear/adjust FSM and a BCD MM:SS counter (00:00–99:59). It drives four BCD digits plus a per-digit blank mask to the seven-segment mux stage.

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/stopwatch_core_btn_debounce.sv | 66 ++++++
 rtl/stopwatch_core.sv | 220 ++++++++++++++++++++++
 tb/tb_stopwatch_core.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch time-keeping stage: FSM state
// encodings, BCD digit limits, parameter defaults and a BCD digit helper.
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSE  = 2'd2;
  localparam logic [1:0] ST_ADJUST = 2'd3;

  localparam logic [3:0] BCD_ONES_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX = 4'd5;

  localparam int DEB_SAMPLES_DEF = 4;
  localparam int MIN_MAX_DEF     = 99;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } mmss_t;

  // Next value of a single BCD digit that rolls over to 0 past lim.
  function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic [3:0] lim);
    return (d >= lim) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/stopwatch_core_btn_debounce.sv
// Raw input conditioner: 2-flop synchroniser, sample counter driven by the
// debounce strobe, accepted level and a one-cycle rising-edge pulse.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEB_SAMPLES = DEB_SAMPLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_deb,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [3:0] CNT_LAST = 4'(DEB_SAMPLES - 1);

  logic       sync0_q, sync0_d;
  logic       sync1_q, sync1_d;
  logic [3:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       level_dly_q, level_dly_d;

  // Synchronise, then count consecutive differing samples until acceptance.
  always_comb begin
    sync0_d     = raw;
    sync1_d     = sync0_q;
    level_dly_d = level_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    if (tick_deb) begin
      if (sync1_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_d = ~level_q;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        cnt_d = 4'd0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0_q     <= 1'b0;
      sync1_q     <= 1'b0;
      cnt_q       <= 4'd0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      sync0_q     <= sync0_d;
      sync1_q     <= sync1_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
    end
  end

  assign level = level_q;
  // High during the first cycle the accepted level reads 1.
  assign rise  = level_q & ~level_dly_q;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: debounced controls, run/pause/clear/adjust FSM and a BCD
// MM:SS counter feeding the seven-segment mux.
// Optional build macro LAP_HOLD_EN adds btn_lap and a display freeze.
//
// state     | meaning
// ----------+---------------------------------------------------
// ST_IDLE   | cleared, waiting for pause press or adjust switch
// ST_RUN    | counting one second per tick_1hz
// ST_PAUSE  | count held, may resume or enter adjust
// ST_ADJUST | selected field steps on tick_2hz, field blinks
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int DEB_SAMPLES = DEB_SAMPLES_DEF,
  parameter int MIN_MAX     = MIN_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       tick_deb,
  input  logic       blink,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic       sw_adj,
  input  logic       sw_sel,
`ifdef LAP_HOLD_EN
  input  logic       btn_lap,
`endif
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] blank,
  output logic       running,
  output logic       wrap
);

  localparam logic [3:0] MIN_T_MAX = 4'(MIN_MAX / 10);
  localparam logic [3:0] MIN_O_MAX = 4'(MIN_MAX % 10);

  logic pause_p, clear_p, adj_lvl, sel_lvl;
  logic pause_lvl, clear_lvl, adj_rise, sel_rise;

  btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_pause (
    .clk(clk), .rst(rst), .tick_deb(tick_deb), .raw(btn_pause),
    .level(pause_lvl), .rise(pause_p));

  btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_clear (
    .clk(clk), .rst(rst), .tick_deb(tick_deb), .raw(btn_clear),
    .level(clear_lvl), .rise(clear_p));

  btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_adj (
    .clk(clk), .rst(rst), .tick_deb(tick_deb), .raw(sw_adj),
    .level(adj_lvl), .rise(adj_rise));

  btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_sel (
    .clk(clk), .rst(rst), .tick_deb(tick_deb), .raw(sw_sel),
    .level(sel_lvl), .rise(sel_rise));

  logic [1:0] state_q, state_d;
  mmss_t      live_q, live_d;
  logic       wrap_q, wrap_d;
  logic [3:0] blank_q, blank_d;
  mmss_t      disp;

  logic       sec_at_max, min_at_max;
  logic [3:0] sec_t_nx, sec_o_nx, min_t_nx, min_o_nx;

`ifdef LAP_HOLD_EN
  logic  lap_p, lap_lvl;
  logic  hold_q, hold_d;
  mmss_t held_q, held_d;

  btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_lap (
    .clk(clk), .rst(rst), .tick_deb(tick_deb), .raw(btn_lap),
    .level(lap_lvl), .rise(lap_p));

  logic unused_ok;
  assign unused_ok = &{1'b0, pause_lvl, clear_lvl, adj_rise, sel_rise, lap_lvl};
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, pause_lvl, clear_lvl, adj_rise, sel_rise};
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; clear overrides every other request.
  always_comb begin
    state_d = state_q;
    if (clear_p) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pause_p)      state_d = ST_RUN;
          else if (adj_lvl) state_d = ST_ADJUST;
        end
        ST_RUN: begin
          if (pause_p) state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (pause_p)      state_d = ST_RUN;
          else if (adj_lvl) state_d = ST_ADJUST;
        end
        ST_ADJUST: begin
          if (!adj_lvl) state_d = ST_PAUSE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    running  = (state_q == ST_RUN);
    wrap     = wrap_q;
    blank    = blank_q;
    min_tens = disp.min_tens;
    min_ones = disp.min_ones;
    sec_tens = disp.sec_tens;
    sec_ones = disp.sec_ones;
  end

  // Field increments shared by counting and adjusting; seconds roll 59->00,
  // minutes roll MIN_MAX->00.
  always_comb begin
    sec_at_max = (live_q.sec_tens == BCD_TENS_MAX) && (live_q.sec_ones == BCD_ONES_MAX);
    min_at_max = (live_q.min_tens == MIN_T_MAX) && (live_q.min_ones == MIN_O_MAX);
    sec_o_nx   = bcd_next(live_q.sec_ones, BCD_ONES_MAX);
    sec_t_nx   = (live_q.sec_ones == BCD_ONES_MAX) ?
                 bcd_next(live_q.sec_tens, BCD_TENS_MAX) : live_q.sec_tens;
    if (min_at_max) begin
      min_t_nx = 4'd0;
      min_o_nx = 4'd0;
    end else if (live_q.min_ones == BCD_ONES_MAX) begin
      min_t_nx = live_q.min_tens + 4'd1;
      min_o_nx = 4'd0;
    end else begin
      min_t_nx = live_q.min_tens;
      min_o_nx = live_q.min_ones + 4'd1;
    end
  end

  // Live count update, wrap pulse and blink mask.
  always_comb begin
    live_d = live_q;
    wrap_d = 1'b0;
    if (clear_p) begin
      live_d = '0;
    end else if ((state_q == ST_RUN) && tick_1hz) begin
      live_d.sec_ones = sec_o_nx;
      live_d.sec_tens = sec_t_nx;
      if (sec_at_max) begin
        live_d.min_tens = min_t_nx;
        live_d.min_ones = min_o_nx;
        wrap_d          = min_at_max;
      end
    end else if ((state_q == ST_ADJUST) && tick_2hz) begin
      if (sel_lvl) begin
        live_d.min_tens = min_t_nx;
        live_d.min_ones = min_o_nx;
      end else begin
        live_d.sec_ones = sec_o_nx;
        live_d.sec_tens = sec_t_nx;
      end
    end
    // Computed from the next state so the mask lines up with state_q.
    blank_d = 4'b0000;
    if ((state_d == ST_ADJUST) && !blink)
      blank_d = sel_lvl ? 4'b1100 : 4'b0011;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q  <= '0;
      wrap_q  <= 1'b0;
      blank_q <= 4'b0000;
    end else begin
      live_q  <= live_d;
      wrap_q  <= wrap_d;
      blank_q <= blank_d;
    end
  end

`ifdef LAP_HOLD_EN
  // Lap freeze: toggled by lap presses in RUN, dropped on clear or leaving RUN.
  always_comb begin
    hold_d = hold_q;
    held_d = held_q;
    if (clear_p || (state_d != ST_RUN)) begin
      hold_d = 1'b0;
    end else if (lap_p && (state_q == ST_RUN)) begin
      hold_d = ~hold_q;
      if (!hold_q) held_d = live_q;
    end
  end

  // Lap freeze registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= 1'b0;
      held_q <= '0;
    end else begin
      hold_q <= hold_d;
      held_q <= held_d;
    end
  end

  assign disp = hold_q ? held_q : live_q;
`else
  assign disp = live_q;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: table-driven tick vectors plus
// hand-written sequences for debounce, adjust, clear priority and reset.
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0, tick_2hz = 1'b0, tick_deb = 1'b1, blink = 1'b1;
  logic       btn_pause = 1'b0, btn_clear = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
`ifdef LAP_HOLD_EN
  logic       btn_lap = 1'b0;
`endif
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blank;
  logic       running, wrap;

  int n_vec  = 0;
  int n_miss = 0;

  stopwatch_core #(.DEB_SAMPLES(4), .MIN_MAX(99)) dut (
    .clk(clk), .rst(rst),
    .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_deb(tick_deb), .blink(blink),
    .btn_pause(btn_pause), .btn_clear(btn_clear), .sw_adj(sw_adj), .sw_sel(sw_sel),
`ifdef LAP_HOLD_EN
    .btn_lap(btn_lap),
`endif
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .blank(blank), .running(running), .wrap(wrap));

  always #5 clk = ~clk;

  typedef struct {
    logic        t1;
    logic        t2;
    logic        blk;
    logic [15:0] dig;
    logic [3:0]  blank;
    logic        run;
    logic        wrap;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic t1, input logic t2, input logic blk,
                              input logic [15:0] dig, input logic [3:0] bl,
                              input logic run, input logic wr);
    vec_t v;
    v.t1 = t1; v.t2 = t2; v.blk = blk; v.dig = dig;
    v.blank = bl; v.run = run; v.wrap = wr;
    return v;
  endfunction

  function automatic logic [15:0] digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply_range(input string tag, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      tick_1hz = vecs[i].t1;
      tick_2hz = vecs[i].t2;
      blink    = vecs[i].blk;
      step();
      tick_1hz = 1'b0;
      tick_2hz = 1'b0;
      chk($sformatf("%s[%0d].digits", tag, i), digits(), vecs[i].dig);
      chk($sformatf("%s[%0d].blank", tag, i), {12'd0, blank}, {12'd0, vecs[i].blank});
      chk($sformatf("%s[%0d].running", tag, i), {15'd0, running}, {15'd0, vecs[i].run});
      chk($sformatf("%s[%0d].wrap", tag, i), {15'd0, wrap}, {15'd0, vecs[i].wrap});
    end
    blink = 1'b1;
  endtask

  // Full press: level accepted after 6 cycles, state moves on the 7th.
  task automatic press_pause();
    btn_pause = 1'b1;
    steps(7);
    btn_pause = 1'b0;
    steps(10);
  endtask

  task automatic set_adj(input logic v);
    sw_adj = v;
    steps(10);
  endtask

  task automatic set_sel(input logic v);
    sw_sel = v;
    steps(10);
  endtask

  task automatic adj_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_2hz = 1'b1;
      step();
      tick_2hz = 1'b0;
    end
  endtask

  initial begin
    // Phase A: RUN from 00:00 (idx 0..11)
    vecs.push_back(mk(1, 0, 1, 16'h0001, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0001, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 1, 1, 16'h0001, 4'b0000, 1, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0002, 4'b0000, 1, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0003, 4'b0000, 1, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0004, 4'b0000, 1, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0005, 4'b0000, 1, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0006, 4'b0000, 1, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0007, 4'b0000, 1, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0008, 4'b0000, 1, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0009, 4'b0000, 1, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0010, 4'b0000, 1, 0));
    // Phase B: ADJUST seconds from 00:58 (idx 12..16)
    vecs.push_back(mk(0, 1, 1, 16'h0059, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0001, 4'b0011, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0001, 4'b0011, 0, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0001, 4'b0000, 0, 0));
    // Phase C: ADJUST minutes (idx 17..18)
    vecs.push_back(mk(0, 0, 0, 16'h0001, 4'b1100, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0101, 4'b1100, 0, 0));
    // Phase D: carry 09:59 -> 10:00 (idx 19)
    vecs.push_back(mk(1, 0, 1, 16'h1000, 4'b0000, 1, 0));
    // Phase E: wrap from 99:58 (idx 20..23)
    vecs.push_back(mk(1, 0, 1, 16'h9959, 4'b0000, 1, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0000, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 4'b0000, 1, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0001, 4'b0000, 1, 0));
    // Phase F: IDLE after clear ignores ticks (idx 24..25)
    vecs.push_back(mk(1, 0, 1, 16'h0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h0000, 4'b0000, 0, 0));
    // Phase G: after reset, IDLE until pause press (idx 26)
    vecs.push_back(mk(1, 0, 1, 16'h0000, 4'b0000, 0, 0));

    // Reset state
    steps(2);
    chk("reset.digits", digits(), 16'h0000);
    chk("reset.blank", {12'd0, blank}, 16'd0);
    chk("reset.running", {15'd0, running}, 16'd0);
    chk("reset.wrap", {15'd0, wrap}, 16'd0);
    rst = 1'b0;
    steps(2);

    // Debounce: 3-sample glitch rejected
    btn_pause = 1'b1;
    steps(3);
    btn_pause = 1'b0;
    steps(10);
    chk("glitch.running", {15'd0, running}, 16'd0);

    // Debounce: held press, RUN exactly on the 7th edge
    btn_pause = 1'b1;
    steps(6);
    chk("press.running_before", {15'd0, running}, 16'd0);
    step();
    chk("press.running_after", {15'd0, running}, 16'd1);
    btn_pause = 1'b0;
    steps(10);
    chk("press.still_run", {15'd0, running}, 16'd1);

    apply_range("run", 0, 11);

    // To PAUSE, then ADJUST seconds up to 00:58
    press_pause();
    chk("pause.running", {15'd0, running}, 16'd0);
    set_adj(1'b1);
    adj_ticks(48);
    chk("adj.to_0058", digits(), 16'h0058);
    apply_range("adjsec", 12, 16);
    set_sel(1'b1);
    apply_range("adjmin", 17, 18);
    adj_ticks(8);
    chk("adj.to_0901", digits(), 16'h0901);
    set_sel(1'b0);
    adj_ticks(58);
    chk("adj.to_0959", digits(), 16'h0959);
    blink = 1'b0;
    set_adj(1'b0);
    chk("leave_adj.blank", {12'd0, blank}, 16'd0);
    chk("leave_adj.running", {15'd0, running}, 16'd0);
    blink = 1'b1;
    press_pause();
    chk("resume.running", {15'd0, running}, 16'd1);
    apply_range("carry", 19, 19);

    // Set 99:58 and run through the wrap
    press_pause();
    set_adj(1'b1);
    set_sel(1'b1);
    adj_ticks(89);
    chk("adj.to_9900", digits(), 16'h9900);
    set_sel(1'b0);
    adj_ticks(58);
    chk("adj.to_9958", digits(), 16'h9958);
    set_adj(1'b0);
    press_pause();
    apply_range("wrap", 20, 23);

    // Clear and tick_1hz together in RUN at 12:34
    press_pause();
    set_adj(1'b1);
    set_sel(1'b1);
    adj_ticks(12);
    set_sel(1'b0);
    adj_ticks(33);
    set_adj(1'b0);
    press_pause();
    chk("pre_clear.digits", digits(), 16'h1234);
    chk("pre_clear.running", {15'd0, running}, 16'd1);
    btn_clear = 1'b1;
    steps(6);
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    chk("clear.digits", digits(), 16'h0000);
    chk("clear.running", {15'd0, running}, 16'd0);
    chk("clear.wrap", {15'd0, wrap}, 16'd0);
    btn_clear = 1'b0;
    steps(10);
    apply_range("idle", 24, 25);

    // Asynchronous reset mid-run at 05:17
    set_adj(1'b1);
    set_sel(1'b1);
    adj_ticks(5);
    set_sel(1'b0);
    adj_ticks(17);
    set_adj(1'b0);
    press_pause();
    chk("pre_rst.digits", digits(), 16'h0517);
    chk("pre_rst.running", {15'd0, running}, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst.digits", digits(), 16'h0000);
    chk("async_rst.running", {15'd0, running}, 16'd0);
    chk("async_rst.blank", {12'd0, blank}, 16'd0);
    step();
    rst = 1'b0;
    steps(2);
    apply_range("post_rst", 26, 26);
    press_pause();
    chk("post_rst.running", {15'd0, running}, 16'd1);
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    chk("post_rst.count", digits(), 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
